reg_op_sequencer: RTL and testbench
===================================

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter: IMM_SEXT, default 1, 1 = sign-extend imm8 to 16 bits, 0 = zero-extend.
REQ-002 Port: clk, input, 1, sole clock, rising-edge active.
REQ-003 Port: reset, input, 1, asynchronous active-high reset.
REQ-004 Port: s, input, 1, start request, sampled only in WAIT.
REQ-005 Port: op, input, 2, 00 MOVI, 01 MOV, 10 ADD, 11 CMP.
REQ-006 Port: rd / rn / rm, input, 3 each, destination / operand-A / operand-B register numbers.
REQ-007 Port: imm8, input, 8, immediate for MOVI.
REQ-008 Port: readnum / writenum, output, 3 each, register-file read and write selects.
REQ-009 Port: write, output, 1, register-file write enable.
REQ-010 Port: loada / loadb / loadc / loads, output, 1 each, A, B, C and status register load enables.
REQ-011 Port: asel, output, 1, 1 = ALU A-input forced to zero.
REQ-012 Port: aluop, output, 2, 00 add, 01 subtract.
REQ-013 Port: vsel, output, 1, 0 = C feeds write-back, 1 = sximm feeds write-back.
REQ-014 Port: sximm, output, 16, extended imm8.
REQ-015 Port: w, output, 1, high in WAIT.
REQ-016 Port: done, output, 1, one-cycle completion strobe.
REQ-017 Port: busy_cycles, output, 16, busy-cycle count (see Configuration).

Function
REQ-018 The block SHALL be a Moore FSM with states WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG and WRITE_IMM; all outputs SHALL decode from state and latched fields only.
REQ-019 In WAIT with s=1 at a clock edge, the block SHALL latch op, rd, rn, rm and imm8 and go to DECODE; s is ignored in every other state.
REQ-020 DECODE SHALL go to WRITE_IMM for MOVI, GET_B for MOV, and GET_A for ADD or CMP.
REQ-021 GET_A SHALL drive readnum=rn and loada=1, then go to GET_B; GET_B SHALL drive readnum=rm and loadb=1, then go to ALU.
REQ-022 ALU SHALL drive aluop=00 and loadc=1 for MOV (asel=1) and ADD (asel=0), then go to WRITE_REG; for CMP it SHALL drive aluop=01, loads=1, loadc=0 and done=1, then go to WAIT.
REQ-023 WRITE_REG SHALL drive vsel=0, writenum=rd, write=1 and done=1, then go to WAIT.
REQ-024 WRITE_IMM SHALL drive vsel=1, writenum=rd, write=1 and done=1, then go to WAIT.
REQ-025 Latency from the s-sampling edge to done high SHALL be 2 cycles for MOVI, 4 for MOV, 5 for ADD and 4 for CMP.
REQ-026 Any enable not named for the current state SHALL be 0, and readnum and writenum SHALL be 0 where not named.
REQ-027 sximm SHALL be {8{imm8_latched[7]}, imm8_latched} when IMM_SEXT=1, and {8'h00, imm8_latched} otherwise.
REQ-028 rd equal to rn or rm SHALL need no special handling; write-back occurs only after all reads complete.
REQ-029 s held high SHALL start a new operation on the first edge after return to WAIT, so back-to-back operations have exactly one WAIT cycle between them.

Reset
REQ-030 reset SHALL force state WAIT asynchronously, with w=1 and every enable and done at 0.
REQ-031 On reset, readnum, writenum, vsel, asel and aluop SHALL be 0, all latched fields SHALL be 0, and busy_cycles SHALL be 0.
REQ-032 Reset mid-operation SHALL abort with no write pulse produced after reset asserts.

Configuration
REQ-033 With SEQ_BUSY_CNT_EN defined, busy_cycles SHALL increment by 1 each cycle the state is not WAIT and SHALL saturate at 16'hFFFF.
REQ-034 Without SEQ_BUSY_CNT_EN, busy_cycles SHALL be tied to 16'h0000, no counter logic SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-035 MOVI: rd=3, imm8=8'hF0, IMM_SEXT=1, pulse s -> 2 cycles later write=1, writenum=3, vsel=1, sximm=16'hFFF0, done=1 for one cycle.
REQ-036 ADD: rn=1, rm=2, rd=5, pulse s -> readnum 1 then 2 with loada then loadb, loadc at cycle 4, write to R5 with done at cycle 5.
REQ-037 CMP: rn=4, rm=4 -> aluop=01 and loads=1 at cycle 4, write never asserted, then w=1.
REQ-038 Busy-ignore: s pulsed during GET_B of an ADD -> no second operation starts, and w rises exactly once.
REQ-039 Reset at GET_A of an ADD -> w=1 immediately (asynchronous), no write pulse, and busy_cycles=0.
REQ-040 SEQ_BUSY_CNT_EN defined, MOV then ADD -> busy_cycles=9; undefined -> busy_cycles=0.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
//   Moore FSM that sequences register-file operations. Supported operations
//   are MOVI, MOV, ADD and CMP. A start request (s) is accepted only in WAIT,
//   where op, rd, rn, rm and imm8 are latched. Later states step through
//   operand reads, the ALU step and write-back. Every output decodes from
//   the current state and the latched fields only.
//
//   Optional feature: define SEQ_BUSY_CNT_EN to build a saturating 16-bit
//   counter of non-WAIT cycles on busy_cycles. When it is undefined,
//   busy_cycles is tied to zero. The port list is the same in both builds.
//
// Parameters
//   IMM_SEXT     1 = sign-extend imm8 into sximm, 0 = zero-extend
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   s            start request (sampled only in WAIT)
//   op           00 MOVI, 01 MOV, 10 ADD, 11 CMP
//   rd/rn/rm     destination / operand-A / operand-B register numbers
//   imm8         immediate for MOVI
//   readnum      register-file read select
//   writenum     register-file write select
//   write        register-file write enable
//   loada/b/c/s  A, B, C and status register load enables
//   asel         1 = ALU A-input forced to zero
//   aluop        00 add, 01 subtract
//   vsel         0 = C feeds write-back, 1 = sximm feeds write-back
//   sximm        extended immediate
//   w            high while waiting for a start request
//   done         one-cycle completion strobe
//   busy_cycles  busy-cycle count (zero unless SEQ_BUSY_CNT_EN)
module reg_op_sequencer #(
    parameter int unsigned IMM_SEXT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [1:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [7:0]  imm8,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic [1:0]  aluop,
    output logic        vsel,
    output logic [15:0] sximm,
    output logic        w,
    output logic        done,
    output logic [15:0] busy_cycles
);

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_GET_A     = 3'd2;
    localparam logic [2:0] S_GET_B     = 3'd3;
    localparam logic [2:0] S_ALU       = 3'd4;
    localparam logic [2:0] S_WRITE_REG = 3'd5;
    localparam logic [2:0] S_WRITE_IMM = 3'd6;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    logic [2:0] state_q, state_d;
    logic [1:0] op_q;
    logic [2:0] rd_q, rn_q, rm_q;
    logic [7:0] imm_q;
    logic       start_s;

    assign start_s = (state_q == S_WAIT) && s;

    // State register; reset returns to WAIT asynchronously, aborting any operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction field latch, loaded only when a start is accepted in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= 2'b00;
            rd_q  <= 3'd0;
            rn_q  <= 3'd0;
            rm_q  <= 3'd0;
            imm_q <= 8'h00;
        end else if (start_s) begin
            op_q  <= op;
            rd_q  <= rd;
            rn_q  <= rn;
            rm_q  <= rm;
            imm_q <= imm8;
        end
    end

    // Next-state logic; MOV skips GET_A because its A-input is forced to zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) state_d = S_DECODE;
                else   state_d = S_WAIT;
            end
            S_DECODE: begin
                case (op_q)
                    OP_MOVI: state_d = S_WRITE_IMM;
                    OP_MOV:  state_d = S_GET_B;
                    default: state_d = S_GET_A;
                endcase
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU: begin
                if (op_q == OP_CMP) state_d = S_WAIT;
                else                state_d = S_WRITE_REG;
            end
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore output decode; everything not named for a state stays at zero
    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        aluop    = 2'b00;
        vsel     = 1'b0;
        w        = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_WAIT:   w = 1'b1;
            S_DECODE: w = 1'b0;
            S_GET_A: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_ALU: begin
                if (op_q == OP_CMP) begin
                    aluop = 2'b01;
                    loads = 1'b1;
                    done  = 1'b1;
                end else begin
                    aluop = 2'b00;
                    loadc = 1'b1;
                    asel  = (op_q == OP_MOV);
                end
            end
            S_WRITE_REG: begin
                vsel     = 1'b0;
                writenum = rd_q;
                write    = 1'b1;
                done     = 1'b1;
            end
            S_WRITE_IMM: begin
                vsel     = 1'b1;
                writenum = rd_q;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

    generate
        if (IMM_SEXT != 0) begin : g_sext
            assign sximm = {{8{imm_q[7]}}, imm_q};
        end else begin : g_zext
            assign sximm = {8'h00, imm_q};
        end
    endgenerate

`ifdef SEQ_BUSY_CNT_EN
    logic [15:0] busy_q, busy_d;

    // Busy counter next value: count non-WAIT cycles, hold at all-ones
    always_comb begin
        busy_d = busy_q;
        if ((state_q != S_WAIT) && (busy_q != 16'hFFFF)) begin
            busy_d = busy_q + 16'd1;
        end else begin
            busy_d = busy_q;
        end
    end

    // Busy counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 16'h0000;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: directed and randomized
// operations compared cycle by cycle against an operation-level model.
module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [1:0]  op;
    logic [2:0]  rd, rn, rm;
    logic [7:0]  imm8;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, vsel, w, done;
    logic [1:0]  aluop;
    logic [15:0] sximm, busy_cycles;

    int checks = 0;
    int errors = 0;
    int busy_exp = 0;

`ifdef SEQ_BUSY_CNT_EN
    localparam bit BUSY_ON = 1'b1;
`else
    localparam bit BUSY_ON = 1'b0;
`endif

    reg_op_sequencer #(.IMM_SEXT(1)) dut (
        .clk(clk), .reset(reset), .s(s), .op(op), .rd(rd), .rn(rn), .rm(rm),
        .imm8(imm8), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .aluop(aluop), .vsel(vsel), .sximm(sximm), .w(w),
        .done(done), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    // Expected control word layout:
    // {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, aluop, vsel, done}
    function automatic logic [16:0] ctl(input logic w_, input logic [2:0] rdn,
                                        input logic [2:0] wrn, input logic wr,
                                        input logic la, input logic lb, input logic lc,
                                        input logic ls, input logic as_,
                                        input logic [1:0] ao, input logic vs,
                                        input logic dn);
        return {w_, rdn, wrn, wr, la, lb, lc, ls, as_, ao, vs, dn};
    endfunction

    function automatic logic [16:0] obs_ctl();
        return {w, readnum, writenum, write, loada, loadb, loadc, loads, asel,
                aluop, vsel, done};
    endfunction

    function automatic logic [16:0] idle_ctl();
        return ctl(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   2'b00, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected extended immediate, from arithmetic rather than bit replication
    function automatic logic [15:0] sext_exp(input logic [7:0] im);
        int v;
        v = (im >= 8'd128) ? int'(im) - 256 : int'(im);
        return 16'(v);
    endfunction

    // Runs one operation from a WAIT-cycle negedge to the following WAIT-cycle
    // negedge. hold_s keeps s high at the end; poke_k pulses s during cycle poke_k.
    task automatic run_op(input logic [1:0] o, input logic [2:0] d, input logic [2:0] n,
                          input logic [2:0] m, input logic [7:0] im,
                          input bit hold_s, input int poke_k, input string tag);
        logic [16:0] exp_q[$];
        logic [16:0] e;
        s = 1'b1; op = o; rd = d; rn = n; rm = m; imm8 = im;
        @(posedge clk); #1;
        if (!hold_s) begin
            // Scramble the inputs to show the operation uses latched fields
            s = 1'b0;
            op = 2'($urandom); rd = 3'($urandom); rn = 3'($urandom);
            rm = 3'($urandom); imm8 = 8'($urandom);
        end
        // Cycle 1 is always decode with nothing asserted
        exp_q.push_back(ctl(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        // Operand reads: A then B for ADD/CMP, only B for MOV
        if (o == 2'b10 || o == 2'b11)
            exp_q.push_back(ctl(1'b0, n, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        if (o != 2'b00)
            exp_q.push_back(ctl(1'b0, m, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        // ALU step
        if (o == 2'b01)
            exp_q.push_back(ctl(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
        else if (o == 2'b10)
            exp_q.push_back(ctl(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
        else if (o == 2'b11)
            exp_q.push_back(ctl(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1));
        // Write-back for everything except CMP; MOVI writes the immediate
        if (o != 2'b11)
            exp_q.push_back(ctl(1'b0, 3'd0, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                (o == 2'b00), 1'b1));
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            e = exp_q[k-1];
            chk($sformatf("%s_c%0d", tag, k), 32'(obs_ctl()), 32'(e));
            chk($sformatf("%s_sximm_c%0d", tag, k), 32'(sximm), 32'(sext_exp(im)));
            if (k == poke_k)     s = 1'b1;
            if (k == poke_k + 1) s = 1'b0;
        end
        busy_exp += exp_q.size();
        @(negedge clk);
        chk({tag, "_wait"}, 32'(obs_ctl()), 32'(idle_ctl()));
        chk({tag, "_busy"}, 32'(busy_cycles), BUSY_ON ? 32'(busy_exp) : 32'd0);
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; op = 2'b00; rd = 3'd0; rn = 3'd0; rm = 3'd0; imm8 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'(obs_ctl()), 32'(idle_ctl()));
        chk("reset_sximm", 32'(sximm), 32'd0);
        chk("reset_busy", 32'(busy_cycles), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // MOV then ADD: busy count 4 + 5
        run_op(2'b01, 3'd6, 3'd0, 3'd7, 8'h12, 1'b0, 0, "mov");
        run_op(2'b10, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, 0, "add");
        chk("busy_mov_add", 32'(busy_cycles), BUSY_ON ? 32'd9 : 32'd0);

        // MOVI with negative immediate, then MOVI with positive immediate
        run_op(2'b00, 3'd3, 3'd0, 3'd0, 8'hF0, 1'b0, 0, "movi_neg");
        run_op(2'b00, 3'd7, 3'd0, 3'd0, 8'h7F, 1'b0, 0, "movi_pos");
        run_op(2'b00, 3'd1, 3'd0, 3'd0, 8'h80, 1'b0, 0, "movi_min");

        // CMP same register
        run_op(2'b11, 3'd2, 3'd4, 3'd4, 8'h00, 1'b0, 0, "cmp");

        // s pulsed during GET_B (cycle 3) of an ADD is ignored; WAIT persists
        run_op(2'b10, 3'd4, 3'd4, 3'd5, 8'h00, 1'b0, 3, "add_busy_s");
        @(negedge clk);
        chk("busy_ignore_wait2", 32'(obs_ctl()), 32'(idle_ctl()));

        // s held high: back-to-back operations with one WAIT cycle between
        run_op(2'b10, 3'd1, 3'd1, 3'd1, 8'h00, 1'b1, 0, "b2b_first");
        run_op(2'b10, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 0, "b2b_second");

        // Randomized operations
        for (int i = 0; i < 12; i++) begin
            run_op(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   8'($urandom), 1'b0, 0, $sformatf("rnd%0d", i));
        end

        // Reset during GET_A of an ADD aborts immediately with no write
        s = 1'b1; op = 2'b10; rd = 3'd6; rn = 3'd2; rm = 3'd3; imm8 = 8'hA5;
        @(posedge clk); #1;
        s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_geta", 32'(obs_ctl()),
            32'(ctl(1'b0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0)));
        reset = 1'b1;
        #1;
        busy_exp = 0;
        chk("abort_async_ctl", 32'(obs_ctl()), 32'(idle_ctl()));
        chk("abort_sximm", 32'(sximm), 32'd0);
        chk("abort_busy", 32'(busy_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_after_%0d", k), 32'(obs_ctl()), 32'(idle_ctl()));
        end
        chk("abort_busy_after", 32'(busy_cycles), 32'd0);

        // Normal operation resumes after the abort
        run_op(2'b01, 3'd0, 3'd0, 3'd5, 8'h00, 1'b0, 0, "post_reset_mov");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
